reg_read_stage: RTL and testbench

- Operand-fetch stage of the pipelined RISC-V core.
- Drives the register-file read addresses and captures the read data.
- Resolves RAW hazards against in-flight EX/MEM/WB results, either by forwarding or by a load-use stall.
- Presents registered operands to the execute stage through a valid/ready handshake.

---
 rtl/reg_read_stage_pkg.sv | 20 ++
 rtl/reg_read_stage_fwd_mux.sv | 44 ++++
 rtl/reg_read_stage.sv | 162 ++++++++++++++++
 tb/tb_reg_read_stage.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/reg_read_stage_pkg.sv
// Shared definitions for the operand-fetch stage: register address width,
// the x0 tag, the forwarding-select encoding and the stall FSM states.
package reg_read_stage_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] X0 = 5'd0;

  typedef enum logic [1:0] {
    FWD_ZERO,
    FWD_EX,
    FWD_MEM,
    FWD_RF
  } fwd_sel_e;

  typedef enum logic {
    ST_RUN,
    ST_STALL
  } rr_state_e;

endpackage

// File: rtl/reg_read_stage_fwd_mux.sv
// Per-operand forwarding mux: x0, then EX (non-load), then MEM, then the
// register file. WB is not bypassed because the register file is written on the falling edge.
module operand_fwd_mux
  import reg_read_stage_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic [REG_ADDR_W-1:0] rs_i,
  input  logic                  ex_valid_i,
  input  logic                  ex_rd_we_i,
  input  logic                  ex_is_load_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic [N-1:0]          ex_data_i,
  input  logic                  mem_valid_i,
  input  logic                  mem_rd_we_i,
  input  logic [REG_ADDR_W-1:0] mem_rd_i,
  input  logic [N-1:0]          mem_data_i,
  input  logic [N-1:0]          rf_data_i,
  output logic [N-1:0]          operand_o,
  output fwd_sel_e              sel_o
);

  always_comb begin
    sel_o = FWD_RF;
    if (rs_i == X0) begin
      sel_o = FWD_ZERO;
    end else if (ex_valid_i && ex_rd_we_i && !ex_is_load_i && (ex_rd_i == rs_i)) begin
      sel_o = FWD_EX;
    end else if (mem_valid_i && mem_rd_we_i && (mem_rd_i == rs_i)) begin
      sel_o = FWD_MEM;
    end
  end

  always_comb begin
    operand_o = rf_data_i;
    unique case (sel_o)
      FWD_ZERO: operand_o = '0;
      FWD_EX:   operand_o = ex_data_i;
      FWD_MEM:  operand_o = mem_data_i;
      default:  operand_o = rf_data_i;
    endcase
  end

endmodule

// File: rtl/reg_read_stage.sv
// Operand-fetch stage: reads the register file, forwards from EX/MEM, stalls
// on load-use hazards and hands registered operands to EX via valid/ready.
module reg_read_stage
  import reg_read_stage_pkg::*;
#(
  parameter int unsigned N     = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [4:0]       in_rd,
  input  logic             in_rd_we,
  input  logic             in_is_load,
  output logic [4:0]       rf_src1,
  output logic [4:0]       rf_src2,
  input  logic [N-1:0]     rf_out1,
  input  logic [N-1:0]     rf_out2,
  input  logic             ex_valid,
  input  logic             ex_rd_we,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic [N-1:0]     ex_data,
  input  logic             mem_valid,
  input  logic             mem_rd_we,
  input  logic [4:0]       mem_rd,
  input  logic [N-1:0]     mem_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     op1,
  output logic [N-1:0]     op2,
  output logic [4:0]       out_rd,
  output logic             out_rd_we,
  output logic             out_is_load,
  output logic [CNT_W-1:0] stall_cnt
);

  rr_state_e        state_q, state_d;
  logic             valid_q, valid_d;
  logic [N-1:0]     op1_q, op1_d, op2_q, op2_d;
  logic [4:0]       rd_q, rd_d;
  logic             rd_we_q, rd_we_d;
  logic             is_load_q, is_load_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N-1:0] fwd1, fwd2;
  fwd_sel_e     sel1, sel2;
  logic         hazard, adv;
  logic         unused_fwd_sel;

  assign rf_src1 = in_rs1;
  assign rf_src2 = in_rs2;

  operand_fwd_mux #(.N(N)) u_fwd1 (
    .rs_i        (in_rs1),
    .ex_valid_i  (ex_valid),
    .ex_rd_we_i  (ex_rd_we),
    .ex_is_load_i(ex_is_load),
    .ex_rd_i     (ex_rd),
    .ex_data_i   (ex_data),
    .mem_valid_i (mem_valid),
    .mem_rd_we_i (mem_rd_we),
    .mem_rd_i    (mem_rd),
    .mem_data_i  (mem_data),
    .rf_data_i   (rf_out1),
    .operand_o   (fwd1),
    .sel_o       (sel1)
  );

  operand_fwd_mux #(.N(N)) u_fwd2 (
    .rs_i        (in_rs2),
    .ex_valid_i  (ex_valid),
    .ex_rd_we_i  (ex_rd_we),
    .ex_is_load_i(ex_is_load),
    .ex_rd_i     (ex_rd),
    .ex_data_i   (ex_data),
    .mem_valid_i (mem_valid),
    .mem_rd_we_i (mem_rd_we),
    .mem_rd_i    (mem_rd),
    .mem_data_i  (mem_data),
    .rf_data_i   (rf_out2),
    .operand_o   (fwd2),
    .sel_o       (sel2)
  );

  // Select codes are useful when probing the mux; the datapath only needs the operands.
  assign unused_fwd_sel = ^{sel1, sel2};

  // Both sources are compared even for formats without rs2; a spurious stall is harmless.
  assign hazard = in_valid && ex_valid && ex_is_load && ex_rd_we && (ex_rd != X0) &&
                  ((ex_rd == in_rs1) || (ex_rd == in_rs2));
  assign adv      = !valid_q || out_ready;
  assign in_ready = adv && !hazard && !flush && !rst;

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    rd_d      = rd_q;
    rd_we_d   = rd_we_q;
    is_load_d = is_load_q;
    cnt_d     = cnt_q;

    if (flush) begin
      valid_d = 1'b0;
    end else if (adv && in_valid && !hazard) begin
      valid_d   = 1'b1;
      op1_d     = fwd1;
      op2_d     = fwd2;
      rd_d      = in_rd;
      rd_we_d   = in_rd_we;
      is_load_d = in_is_load;
    end else if (adv && hazard) begin
      valid_d = 1'b0;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end else if (adv) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      ST_RUN:   if (adv && hazard && !flush) state_d = ST_STALL;
      ST_STALL: if (!hazard || flush)        state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      valid_q   <= 1'b0;
      op1_q     <= '0;
      op2_q     <= '0;
      rd_q      <= '0;
      rd_we_q   <= 1'b0;
      is_load_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      rd_q      <= rd_d;
      rd_we_q   <= rd_we_d;
      is_load_q <= is_load_d;
      cnt_q     <= cnt_d;
    end
  end

  assign out_valid   = valid_q;
  assign op1         = op1_q;
  assign op2         = op2_q;
  assign out_rd      = rd_q;
  assign out_rd_we   = rd_we_q;
  assign out_is_load = is_load_q;
  assign stall_cnt   = cnt_q;

endmodule

// File: tb/tb_reg_read_stage.sv
// Directed bench for reg_read_stage: forwarding, load-use stall, backpressure,
// flush and counter saturation (second instance with a 2-bit counter).
module tb_reg_read_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_rd_we, in_is_load;
  logic [31:0] rf_out1, rf_out2;
  logic        ex_valid, ex_rd_we, ex_is_load;
  logic [4:0]  ex_rd;
  logic [31:0] ex_data;
  logic        mem_valid, mem_rd_we;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        out_ready;

  logic        in_ready, out_valid, out_rd_we, out_is_load;
  logic [4:0]  rf_src1, rf_src2, out_rd;
  logic [31:0] op1, op2;
  logic [15:0] stall_cnt;

  logic        s_in_ready, s_out_valid, s_out_rd_we, s_out_is_load;
  logic [4:0]  s_rf_src1, s_rf_src2, s_out_rd;
  logic [31:0] s_op1, s_op2;
  logic [1:0]  s_stall_cnt;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;

  reg_read_stage #(.N(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_we(in_rd_we),
    .in_is_load(in_is_load), .rf_src1(rf_src1), .rf_src2(rf_src2),
    .rf_out1(rf_out1), .rf_out2(rf_out2), .ex_valid(ex_valid), .ex_rd_we(ex_rd_we),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_data(ex_data), .mem_valid(mem_valid),
    .mem_rd_we(mem_rd_we), .mem_rd(mem_rd), .mem_data(mem_data), .out_valid(out_valid),
    .out_ready(out_ready), .op1(op1), .op2(op2), .out_rd(out_rd), .out_rd_we(out_rd_we),
    .out_is_load(out_is_load), .stall_cnt(stall_cnt)
  );

  reg_read_stage #(.N(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_we(in_rd_we),
    .in_is_load(in_is_load), .rf_src1(s_rf_src1), .rf_src2(s_rf_src2),
    .rf_out1(rf_out1), .rf_out2(rf_out2), .ex_valid(ex_valid), .ex_rd_we(ex_rd_we),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_data(ex_data), .mem_valid(mem_valid),
    .mem_rd_we(mem_rd_we), .mem_rd(mem_rd), .mem_data(mem_data), .out_valid(s_out_valid),
    .out_ready(out_ready), .op1(s_op1), .op2(s_op2), .out_rd(s_out_rd),
    .out_rd_we(s_out_rd_we), .out_is_load(s_out_is_load), .stall_cnt(s_stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1;
    in_rs1 = 5'd0; in_rs2 = 5'd0; in_rd = 5'd0; in_rd_we = 1'b0; in_is_load = 1'b0;
    rf_out1 = '0; rf_out2 = '0;
    ex_valid = 1'b0; ex_rd_we = 1'b0; ex_is_load = 1'b0; ex_rd = 5'd0; ex_data = '0;
    mem_valid = 1'b0; mem_rd_we = 1'b0; mem_rd = 5'd0; mem_data = '0;
    out_ready = 1'b1;

    // Reset held two cycles with an instruction offered
    tick(); tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_op1", op1, 32'd0);
    check("rst_op2", op2, 32'd0);
    check("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_sat_cnt", {30'd0, s_stall_cnt}, 32'd0);
    rst = 1'b0;

    // EX forward on rs1, register file on rs2
    in_rs1 = 5'd5; in_rs2 = 5'd6; in_rd = 5'd10; in_rd_we = 1'b1;
    rf_out1 = 32'h0000_0999; rf_out2 = 32'h77;
    ex_valid = 1'b1; ex_rd_we = 1'b1; ex_rd = 5'd5; ex_data = 32'h1234;
    #1;
    check("rf_src1", {27'd0, rf_src1}, 32'd5);
    check("rf_src2", {27'd0, rf_src2}, 32'd6);
    check("exfwd_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("exfwd_valid", {31'd0, out_valid}, 32'd1);
    check("exfwd_op1", op1, 32'h1234);
    check("exfwd_op2", op2, 32'h77);
    check("exfwd_rd", {27'd0, out_rd}, 32'd10);
    check("exfwd_rd_we", {31'd0, out_rd_we}, 32'd1);

    // EX beats MEM for the same register
    in_rs1 = 5'd3; in_rs2 = 5'd0; in_rd = 5'd11;
    ex_rd = 5'd3; ex_data = 32'hA;
    mem_valid = 1'b1; mem_rd_we = 1'b1; mem_rd = 5'd3; mem_data = 32'hB;
    rf_out2 = 32'h123;
    tick();
    check("prio_op1", op1, 32'hA);
    check("prio_op2_x0", op2, 32'd0);

    // x0 never forwards; rs2 picks up MEM
    in_rs1 = 5'd0; in_rs2 = 5'd3; ex_rd = 5'd0; ex_data = 32'h55;
    rf_out1 = 32'h111; rf_out2 = 32'h999;
    tick();
    check("x0_op1", op1, 32'd0);
    check("memfwd_op2", op2, 32'hB);

    // Load-use hazard on rs2
    mem_valid = 1'b0;
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd_we = 1'b1; ex_rd = 5'd7; ex_data = 32'hBAD;
    in_rs1 = 5'd1; in_rs2 = 5'd7; in_rd = 5'd8; in_is_load = 1'b0;
    rf_out1 = 32'h11; rf_out2 = 32'h22;
    #1;
    check("lu_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check("lu_bubble", {31'd0, out_valid}, 32'd0);
    check("lu_stall_cnt", {16'd0, stall_cnt}, 32'd1);

    // Load now in MEM: the instruction goes through with forwarded data
    ex_valid = 1'b0; ex_is_load = 1'b0;
    mem_valid = 1'b1; mem_rd_we = 1'b1; mem_rd = 5'd7; mem_data = 32'hDEAD;
    #1;
    check("lu_release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("lu_valid", {31'd0, out_valid}, 32'd1);
    check("lu_op1", op1, 32'h11);
    check("lu_op2", op2, 32'hDEAD);
    check("lu_rd", {27'd0, out_rd}, 32'd8);

    // Backpressure with a pending hazard: outputs frozen, counter untouched
    out_ready = 1'b0; mem_valid = 1'b0;
    in_rs1 = 5'd2; in_rs2 = 5'd4; in_rd = 5'd9; rf_out1 = 32'h1;
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_op1", op1, 32'h11);
      check("bp_op2", op2, 32'hDEAD);
      check("bp_rd", {27'd0, out_rd}, 32'd8);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    check("bp_stall_cnt", {16'd0, stall_cnt}, 32'd1);

    // Flush while stalled downstream and with a hazard present
    flush = 1'b1;
    #1;
    check("flush_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_stall_cnt", {16'd0, stall_cnt}, 32'd1);
    flush = 1'b0; out_ready = 1'b1;

    // Five hazard cycles: 16-bit counter 1->6, 2-bit counter saturates at 3
    for (int i = 0; i < 5; i++) tick();
    check("sat_wide_cnt", {16'd0, stall_cnt}, 32'd6);
    check("sat_narrow_cnt", {30'd0, s_stall_cnt}, 32'd3);
    check("sat_bubble", {31'd0, out_valid}, 32'd0);

    // Hazard clears: instruction accepted from the register file
    ex_valid = 1'b0; ex_is_load = 1'b0;
    tick();
    check("post_valid", {31'd0, out_valid}, 32'd1);
    check("post_op1", op1, 32'h1);
    check("post_rd", {27'd0, out_rd}, 32'd9);

    // Reset in the middle of a stall
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd4;
    tick();
    check("pre_rst_cnt", {16'd0, stall_cnt}, 32'd7);
    rst = 1'b1;
    tick();
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_cnt", {16'd0, stall_cnt}, 32'd0);
    check("midrst_op1", op1, 32'd0);
    rst = 1'b0; ex_valid = 1'b0; ex_is_load = 1'b0;
    tick();
    check("after_rst_valid", {31'd0, out_valid}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
